// File: rtl/tick_divider_pkg.sv
// rtl/tick_divider_pkg.sv - shared timing constants and helper functions for tick_divider
//   CLK_FREQ_HZ    : system clock frequency
//   clog2()        : ceiling log2, for sizing counters
//   hz_to_period() : clocks per tick for a desired tick rate
package tick_divider_pkg;

  localparam int unsigned CLK_FREQ_HZ = 27_000_000;

  function automatic int clog2(input longint unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 63; i++) begin
      if (value > (64'd1 << i)) result = i + 1;
    end
    return result;
  endfunction

  function automatic int unsigned hz_to_period(input int unsigned freq_hz);
    return CLK_FREQ_HZ / freq_hz;
  endfunction

  // 25 bits: enough to hold a 1 Hz period at the system clock.
  localparam int DEFAULT_CNT_W = clog2(CLK_FREQ_HZ);

endpackage

// File: rtl/tick_divider_channel.sv
// rtl/tick_divider_channel.sv - one programmable tick channel (counter, reload, pause, square)
//   clk, reset : system clock, synchronous active-high reset
//   start      : restart pulse; loads period-1 and arms when period != 0
//   run        : 1 = count, 0 = pause (counter frozen, tick low)
//   period     : clocks between ticks, sampled at start and at each reload
//   tick       : registered one-clock pulse per elapsed period
//   running    : channel armed
//   square     : toggles on every tick (macro TICK_DIVIDER_SQUARE_EN), else tied 0
module tick_divider_channel
  import tick_divider_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  output logic             tick,
  output logic             running,
  output logic             square
);

  logic [CNT_W-1:0] counter;
  logic             period_zero;
  logic             terminal;

  assign period_zero = (period == '0);
  // Terminal count only matters while armed and enabled; start overrides it.
  assign terminal    = running && run && (counter == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      running <= 1'b0;
      tick    <= 1'b0;
    end else if (start) begin
      counter <= period_zero ? '0 : period - CNT_W'(1);
      running <= !period_zero;
      tick    <= 1'b0;
    end else if (running && run) begin
      if (counter == '0) begin
        tick <= 1'b1;
        if (period_zero) begin
          running <= 1'b0;
          counter <= '0;
        end else begin
          counter <= period - CNT_W'(1);
        end
      end else begin
        counter <= counter - CNT_W'(1);
        tick    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

`ifdef TICK_DIVIDER_SQUARE_EN
  logic square_q;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      square_q <= 1'b0;
    end else if (terminal) begin
      square_q <= ~square_q;
    end
  end

  assign square = square_q;
`else
  logic unused_terminal;
  assign unused_terminal = terminal;
  assign square          = 1'b0;
`endif

endmodule

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - multi-channel run-time-programmable tick generator
//   optional feature macro: TICK_DIVIDER_SQUARE_EN (square-wave outputs)
//   clk         : system clock
//   reset       : synchronous active-high reset
//   start_timer : per-channel restart pulse
//   run         : per-channel run enable (0 = pause)
//   period      : packed periods, channel i at [i*CNT_W +: CNT_W]
//   tick        : per-channel one-clock enable pulse
//   running     : per-channel armed flag
//   square      : per-channel square wave (0 when feature disabled)
module tick_divider
  import tick_divider_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       start_timer,
  input  logic [NUM_CH-1:0]       run,
  input  logic [NUM_CH*CNT_W-1:0] period,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       square
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_divider_channel #(
      .CNT_W(CNT_W)
    ) u_channel (
      .clk    (clk),
      .reset  (reset),
      .start  (start_timer[i]),
      .run    (run[i]),
      .period (period[i*CNT_W +: CNT_W]),
      .tick   (tick[i]),
      .running(running[i]),
      .square (square[i])
    );
  end

endmodule

// File: tb/tb_tick_divider.sv
// tb/tb_tick_divider.sv - scoreboard bench for tick_divider against a cycles-remaining model
module tb_tick_divider;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       start_timer;
  logic [NUM_CH-1:0]       run;
  logic [NUM_CH*CNT_W-1:0] period;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       running;
  logic [NUM_CH-1:0]       square;

  tick_divider #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_timer(start_timer),
    .run        (run),
    .period     (period),
    .tick       (tick),
    .running    (running),
    .square     (square)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] square;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   done   = 1'b0;

  // Model: number of enabled cycles still to elapse before the next tick.
  int rem[NUM_CH];
  bit m_run[NUM_CH];
  bit m_tick[NUM_CH];
  int m_ticks[NUM_CH];

  task automatic model_step();
    exp_t e;
    for (int c = 0; c < NUM_CH; c++) begin
      int p;
      p = int'(period[c*CNT_W +: CNT_W]);
      m_tick[c] = 1'b0;
      if (reset) begin
        rem[c] = 0; m_run[c] = 1'b0; m_ticks[c] = 0;
      end else if (start_timer[c]) begin
        rem[c] = p; m_run[c] = (p != 0); m_ticks[c] = 0;
      end else if (m_run[c] && run[c]) begin
        rem[c] = rem[c] - 1;
        if (rem[c] == 0) begin
          m_tick[c]  = 1'b1;
          m_ticks[c] = m_ticks[c] + 1;
          rem[c]     = p;
          if (p == 0) m_run[c] = 1'b0;
        end
      end
      e.tick[c]    = m_tick[c];
      e.running[c] = m_run[c];
`ifdef TICK_DIVIDER_SQUARE_EN
      e.square[c]  = m_ticks[c][0];
`else
      e.square[c]  = 1'b0;
`endif
    end
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cycle, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!done) begin
        model_step();
        cycle++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty cycle %0d: got 0 entries expected 1", cycle);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("tick", tick, e.tick);
          check("running", running, e.running);
          check("square", square, e.square);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_period(input int c, input int p);
    period[c*CNT_W +: CNT_W] = CNT_W'(p);
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] mask);
    start_timer = mask;
    step(1);
    start_timer = '0;
  endtask

  initial begin
    reset       = 1'b1;
    start_timer = '0;
    run         = '0;
    period      = '0;
    step(3);
    reset = 1'b0;
    run   = '1;
    set_period(0, 5);
    set_period(1, 7);
    step(50);

    // Basic 5-clock period, then a 3-cycle pause mid-period.
    pulse_start(2'b01);
    step(6);
    run[0] = 1'b0;
    step(3);
    run[0] = 1'b1;
    step(12);

    // Mid-period change to 3 takes effect at the next reload, then restart on terminal count.
    pulse_start(2'b01);
    step(1);
    set_period(0, 3);
    step(10);
    set_period(0, 5);
    for (int i = 0; i < 20 && !(dut.g_ch[0].u_channel.counter == 0); i++) step(1);
    pulse_start(2'b01);
    step(12);

    // Channel 1: period 0 never arms; period 1 ticks every clock.
    set_period(1, 0);
    pulse_start(2'b10);
    step(10);
    set_period(1, 1);
    pulse_start(2'b10);
    step(10);

    // Start while paused, then simultaneous starts on both channels.
    run = 2'b00;
    set_period(0, 4);
    pulse_start(2'b01);
    step(5);
    run = 2'b11;
    step(8);
    set_period(1, 2);
    pulse_start(2'b11);
    step(10);

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        start_timer[c] = ($urandom_range(0, 19) == 0);
        run[c]         = ($urandom_range(0, 99) < 85);
        if ($urandom_range(0, 9) == 0) set_period(c, $urandom_range(1, 12));
      end
      step(1);
    end
    start_timer = '0;
    run         = '1;
    step(10);

    // Reset coincident with start and run wins; nothing ticks afterwards.
    reset       = 1'b1;
    start_timer = '1;
    step(1);
    reset       = 1'b0;
    start_timer = '0;
    step(30);

    done = 1'b1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
